// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, 64-byte lines, refilled from MemCtrl.
// Hits return next cycle; misses bypass the refilled word on ifetch_done.
module icache_direct #(
  parameter int IDX_W = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         fetch_req,
  input  logic [31:0]  fetch_pc,
  output logic         fetch_ready,
  input  logic         flush,
  output logic         inst_valid,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  output logic         ifetch_todo,
  output logic [31:0]  ifetch_addr,
  input  logic [511:0] ifetch_res,
  input  logic         ifetch_done
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 26 - IDX_W;

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_t;

  state_t r_state;
  state_t w_state_n;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [511:0]     r_data [LINES];

  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_drop;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [3:0]       w_word;
  logic [IDX_W-1:0] w_ridx;
  logic [TAG_W-1:0] w_rtag;
  logic [3:0]       w_rword;
  logic             w_hit;
  logic             w_accept;
  logic             w_fill;
  logic [511:0]     w_line;
  logic [31:0]      w_hit_word;
  logic [31:0]      w_byp_word;

  assign w_idx   = fetch_pc[5+IDX_W:6];
  assign w_tag   = fetch_pc[31:6+IDX_W];
  assign w_word  = fetch_pc[5:2];
  assign w_ridx  = r_pc[5+IDX_W:6];
  assign w_rtag  = r_pc[31:6+IDX_W];
  assign w_rword = r_pc[5:2];

  assign fetch_ready = (r_state == S_IDLE);
  assign ifetch_todo = (r_state == S_REFILL) && !ifetch_done;
  assign ifetch_addr = r_addr;
  assign inst_valid  = r_inst_valid;
  assign inst        = r_inst;
  assign inst_pc     = r_inst_pc;

  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_accept = fetch_req && fetch_ready && rdy_in && !flush;
  assign w_fill   = rdy_in && (r_state == S_REFILL) && ifetch_done;

  assign w_line     = r_data[w_idx];
  assign w_hit_word = w_line[{w_word, 5'd0} +: 32];
  assign w_byp_word = ifetch_res[{w_rword, 5'd0} +: 32];

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept && !w_hit) w_state_n = S_REFILL;
      S_REFILL: if (ifetch_done) w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid      <= '0;
      r_pc         <= '0;
      r_addr       <= '0;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
    end else if (rdy_in) begin
      r_inst_valid <= 1'b0;
      if (w_accept && w_hit) begin
        r_inst_valid <= 1'b1;
        r_inst       <= w_hit_word;
        r_inst_pc    <= fetch_pc;
      end
      if (w_accept && !w_hit) begin
        r_pc   <= fetch_pc;
        r_addr <= {fetch_pc[31:6], 6'b0};
      end
      if (r_state == S_REFILL) begin
        if (flush) r_drop <= 1'b1;
        // the line is installed even when the fetch was flushed
        if (ifetch_done) begin
          r_valid[w_ridx] <= 1'b1;
          r_drop          <= 1'b0;
          if (!r_drop && !flush) begin
            r_inst_valid <= 1'b1;
            r_inst       <= w_byp_word;
            r_inst_pc    <= r_pc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_data[w_ridx] <= ifetch_res;
      r_tag[w_ridx]  <= w_rtag;
    end
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the instruction-fetch stage and MemCtrl.
- It is the requesting end of MemCtrl's ifetch interface. It issues 64-byte line refills with `ifetch_todo`/`ifetch_addr` and consumes `ifetch_res` on the `ifetch_done` pulse.
- It returns one 32-bit instruction per accepted PC: next cycle on a hit, after a line refill on a miss.

Parameters:
- IDX_W, 4, index bits; the cache holds 2^IDX_W lines of 64 bytes (default 16 lines, 1 KiB).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset; asynchronous, active-high
- rdy_in  input  1  global enable; when low, all state and outputs hold
- fetch_req  input  1  IF stage requests the instruction at fetch_pc
- fetch_pc  input  32  instruction address; bits [1:0] are ignored
- fetch_ready  output  1  combinational; high iff state==IDLE; a request is accepted when fetch_req && fetch_ready && rdy_in && !flush
- flush  input  1  discard any in-flight request (branch redirect)
- inst_valid  output  1  registered; one-cycle pulse with an instruction
- inst  output  32  instruction word, little-endian
- inst_pc  output  32  PC of inst
- ifetch_todo  output  1  refill request to MemCtrl
- ifetch_addr  output  32  line base address, bits [5:0]=0
- ifetch_res  input  512  refilled line; byte k at bits [8k+7:8k]
- ifetch_done  input  1  one-cycle pulse; ifetch_res is valid in that cycle

Behaviour:
- Address split: offset=pc[5:0], word=pc[5:2], index=pc[5+IDX_W:6], tag=pc[31:6+IDX_W].
- Per line state: valid bit, tag, 512-bit data.
- Reset (async): all valid bits=0, state=IDLE, inst_valid=0, inst=0, inst_pc=0, ifetch_todo=0, ifetch_addr=0, drop=0. Tag and data arrays are not reset.
- rdy_in low: no state changes. fetch_ready and ifetch_todo keep their combinational definitions from held state.
- States are IDLE and REFILL.
- IDLE, accepted request that hits (valid[index] && tag match):
  - Next cycle: inst_valid=1, inst = word `word` of the line, inst_pc = fetch_pc.
  - Stay in IDLE, so back-to-back hits sustain one instruction per cycle.
- IDLE, accepted request that misses:
  - Latch pc and set ifetch_addr = {pc[31:6], 6'b0}; go to REFILL.
  - inst_valid=0 next cycle.
- IDLE, no accepted request: inst_valid=0 next cycle.
- ifetch_todo = (state==REFILL) && !ifetch_done, combinational.
  - It must be low in the cycle ifetch_done is high. MemCtrl is back in IDLE that cycle, and a held request would start a spurious second line fetch.
  - ifetch_addr is stable for the entire REFILL.
- REFILL, waiting for ifetch_done: fetch_ready=0, inst_valid=0.
- REFILL, ifetch_done=1:
  - Write ifetch_res into data[index]; set tag[index] and valid[index]=1.
  - Return to IDLE.
  - If drop=0 and flush=0: next cycle inst_valid=1, inst = word `word` taken from ifetch_res (bypass), inst_pc = latched pc.
  - Clear drop.
- Flush:
  - In IDLE: any simultaneous fetch_req is ignored and inst_valid=0 next cycle.
  - In REFILL: set drop=1. The refill is NOT aborted, because MemCtrl cannot abort. The line is still installed on ifetch_done, but no instruction is delivered.
  - flush coincident with ifetch_done: install the line, suppress inst_valid.
- A refill that overwrites a valid line with a different tag evicts it silently (read-only cache, no writeback).
- Reset mid-REFILL: return to the reset state. MemCtrl shares rst_in, so no stale ifetch_done is expected.
- No self-modifying-code coherence; stores are not snooped.

Test Plan:
- Cold miss: memory byte[a]=a[7:0]; request pc=0x0 -> ifetch_addr=0x0. ifetch_todo is held until ifetch_done and is low in the done cycle. Next cycle inst_valid=1, inst=0x03020100, inst_pc=0x0. MemCtrl starts exactly one line fetch.
- Hit streaming: after the cold miss, pcs 0x4, 0x8, 0x3C on consecutive cycles -> inst=0x07060504, 0x0B0A0908, 0x3F3E3D3C, each one cycle after acceptance, with no ifetch_todo.
- Conflict eviction (IDX_W=4): pc=0x400 -> miss with ifetch_addr=0x400. Afterwards pc=0x0 misses again and refetches 0x0.
- Flush during refill: miss at pc=0x80, assert flush for 1 cycle mid-refill -> no inst_valid after ifetch_done. A following request to pc=0x84 hits with inst=0x87868584.
- flush coincident with ifetch_done -> line installed, no inst_valid. A subsequent request to the same pc hits.
- rdy_in low for 5 cycles during REFILL and during hit streaming -> outputs and state frozen, sequence resumes unchanged. Reset asserted mid-REFILL -> ifetch_todo=0 and inst_valid=0 immediately (asynchronously); after release, pc=0x0 misses.
